// File: rtl/buzzer_pkg.sv
// ============================================================================
// Module      : buzzer_pkg
// Description : Shared state encoding, player count and rotating-priority pick
//               for the buzzer arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package buzzer_pkg;

    localparam int NUM_PLAYERS = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Highest priority goes to ptr, then ptr+1, ... wrapping mod 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] result;
        logic       found;
        result = ptr;
        found  = 1'b0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/buzzer_arbiter_debouncer.sv
// ============================================================================
// Module      : debouncer
// Description : 2-FF synchroniser, active-low to active-high inversion and a
//               saturating stable-count debouncer for one player button.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_W            = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic level_o
);

    logic            sync1_q;
    logic            sync2_q;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;
    logic            level_q;
    logic            level_d;
    logic            w_pressed;

    assign w_pressed = ~sync2_q;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (w_pressed == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= DB_W'(DEBOUNCE_CYCLES)) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else if (cnt_q != {DB_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser idles in the released state so reset never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/buzzer_arbiter.sv
// ============================================================================
// Module      : buzzer_arbiter
// Description : First-press arbiter for four player buttons with arm/clear
//               handshake and rotating tie-break priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module buzzer_arbiter
    import buzzer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_W            = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_n,
    input  logic       arm,
    input  logic       clear,
    output logic       playerInputFlag,
    output logic [1:0] firstPlayerFlag,
    output logic       armed,
    output logic [3:0] btnLevel
);

    logic [3:0] w_level;
    logic [3:0] lvl_prev_q;
    logic [3:0] pe_q;
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [1:0] prio_q;
    logic [1:0] prio_d;
    logic [1:0] winner_q;
    logic [1:0] winner_d;
    logic [1:0] w_pick;
    logic       pif_q;
    logic       armed_q;

    generate
        for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_db
            debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .DB_W           (DB_W)
            ) u_db (
                .clk    (clk),
                .rst    (rst),
                .btn_n_i(btn_n[i]),
                .level_o(w_level[i])
            );
        end
    endgenerate

    assign w_pick = rr_pick(pe_q, prio_q);

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        winner_d = winner_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (|pe_q) begin
                        winner_d = w_pick;
                        prio_d   = w_pick + 2'd1;
                        state_d  = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    state_d = ST_LOCKED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Flags are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_prev_q <= 4'b0000;
            pe_q       <= 4'b0000;
            state_q    <= ST_IDLE;
            prio_q     <= 2'd0;
            winner_q   <= 2'd0;
            pif_q      <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            lvl_prev_q <= w_level;
            pe_q       <= w_level & ~lvl_prev_q;
            state_q    <= state_d;
            prio_q     <= prio_d;
            winner_q   <= winner_d;
            pif_q      <= (state_d == ST_LOCKED);
            armed_q    <= (state_d == ST_ARMED);
        end
    end

    assign playerInputFlag = pif_q;
    assign firstPlayerFlag = winner_q;
    assign armed           = armed_q;
    assign btnLevel        = w_level;

endmodule

`default_nettype wire

// File: tb/tb_buzzer_arbiter.sv
// ============================================================================
// Module      : tb_buzzer_arbiter
// Description : Directed self-checking bench for buzzer_arbiter (debounce = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_buzzer_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] btn_n;
    logic       arm;
    logic       clear;
    logic       playerInputFlag;
    logic [1:0] firstPlayerFlag;
    logic       armed;
    logic [3:0] btnLevel;

    int errors = 0;
    int checks = 0;

    buzzer_arbiter #(
        .DEBOUNCE_CYCLES(4),
        .DB_W           (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_n          (btn_n),
        .arm            (arm),
        .clear          (clear),
        .playerInputFlag(playerInputFlag),
        .firstPlayerFlag(firstPlayerFlag),
        .armed          (armed),
        .btnLevel       (btnLevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        btn_n = 4'hF;
        arm   = 1'b0;
        clear = 1'b0;
        tick(2);
        checks++;
        if ({playerInputFlag, firstPlayerFlag, armed, btnLevel} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want 00000000",
                     {playerInputFlag, firstPlayerFlag, armed, btnLevel});
        end
        rst = 1'b1;
        tick(1);
    endtask

    task automatic test_basic_win();
        pulse_arm();
        checks++;
        if (armed !== 1'b1) begin
            errors++;
            $display("FAIL arm_sets_armed: got %b, want 1", armed);
        end
        btn_n = 4'b1011;
        tick(6);                       // now after edge 5
        checks++;
        if (btnLevel !== 4'b0000) begin
            errors++;
            $display("FAIL level_edge5: got %b, want 0000", btnLevel);
        end
        tick(1);                       // after edge 6
        checks++;
        if (btnLevel !== 4'b0100) begin
            errors++;
            $display("FAIL level_edge6: got %b, want 0100", btnLevel);
        end
        tick(1);                       // after edge 7
        checks++;
        if (playerInputFlag !== 1'b0) begin
            errors++;
            $display("FAIL flag_edge7: got %b, want 0", playerInputFlag);
        end
        tick(1);                       // after edge 8
        checks++;
        if ({playerInputFlag, firstPlayerFlag, armed} !== 4'b1100) begin
            errors++;
            $display("FAIL win_edge8: got pif=%b fpf=%0d armed=%b, want 1 2 0",
                     playerInputFlag, firstPlayerFlag, armed);
        end
        btn_n = 4'hF;
        tick(10);
        pulse_clear();
        checks++;
        if ({playerInputFlag, armed} !== 2'b00 || firstPlayerFlag !== 2'd2) begin
            errors++;
            $display("FAIL clear_after_win: got pif=%b armed=%b fpf=%0d, want 0 0 2",
                     playerInputFlag, armed, firstPlayerFlag);
        end
    endtask

    task automatic test_glitch();
        pulse_arm();
        btn_n = 4'b1101;
        tick(3);
        btn_n = 4'hF;
        tick(12);
        checks++;
        if ({btnLevel, playerInputFlag, armed} !== 6'b000001) begin
            errors++;
            $display("FAIL glitch: got lvl=%b pif=%b armed=%b, want 0000 0 1",
                     btnLevel, playerInputFlag, armed);
        end
        pulse_clear();
    endtask

    task automatic test_tie_break();
        // Reset first so the priority pointer starts at 0.
        test_reset();
        pulse_arm();
        btn_n = 4'b0101;
        tick(12);
        checks++;
        if (playerInputFlag !== 1'b1 || firstPlayerFlag !== 2'd1) begin
            errors++;
            $display("FAIL tie_prio0: got pif=%b fpf=%0d, want 1 1",
                     playerInputFlag, firstPlayerFlag);
        end
        btn_n = 4'hF;
        tick(10);
        pulse_clear();
        pulse_arm();
        btn_n = 4'b0101;
        tick(12);
        checks++;
        if (playerInputFlag !== 1'b1 || firstPlayerFlag !== 2'd3) begin
            errors++;
            $display("FAIL tie_prio2: got pif=%b fpf=%0d, want 1 3",
                     playerInputFlag, firstPlayerFlag);
        end
        btn_n = 4'hF;
        tick(10);
        pulse_clear();
        pulse_arm();
        btn_n = 4'b1010;
        tick(12);
        checks++;
        if (playerInputFlag !== 1'b1 || firstPlayerFlag !== 2'd0) begin
            errors++;
            $display("FAIL tie_prio_wrap: got pif=%b fpf=%0d, want 1 0",
                     playerInputFlag, firstPlayerFlag);
        end
        btn_n = 4'hF;
        tick(10);
        pulse_clear();
    endtask

    task automatic test_held_before_arm();
        btn_n = 4'b1110;
        tick(10);
        pulse_arm();
        tick(10);
        checks++;
        if ({playerInputFlag, armed, btnLevel} !== 6'b010001) begin
            errors++;
            $display("FAIL held_no_win: got pif=%b armed=%b lvl=%b, want 0 1 0001",
                     playerInputFlag, armed, btnLevel);
        end
        btn_n = 4'hF;
        tick(10);
        btn_n = 4'b1110;
        tick(12);
        checks++;
        if (playerInputFlag !== 1'b1 || firstPlayerFlag !== 2'd0) begin
            errors++;
            $display("FAIL held_repress: got pif=%b fpf=%0d, want 1 0",
                     playerInputFlag, firstPlayerFlag);
        end
        // Later press and arm while LOCKED must not disturb the result.
        btn_n = 4'b0110;
        pulse_arm();
        tick(12);
        checks++;
        if (playerInputFlag !== 1'b1 || firstPlayerFlag !== 2'd0 || armed !== 1'b0) begin
            errors++;
            $display("FAIL locked_hold: got pif=%b fpf=%0d armed=%b, want 1 0 0",
                     playerInputFlag, firstPlayerFlag, armed);
        end
        btn_n = 4'hF;
        tick(10);
        pulse_clear();
    endtask

    task automatic test_arm_clear_same();
        arm   = 1'b1;
        clear = 1'b1;
        tick(1);
        arm   = 1'b0;
        clear = 1'b0;
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL arm_clear_same: got armed=%b, want 0", armed);
        end
        btn_n = 4'b0111;
        tick(12);
        checks++;
        if (playerInputFlag !== 1'b0 || btnLevel !== 4'b1000) begin
            errors++;
            $display("FAIL idle_press: got pif=%b lvl=%b, want 0 1000",
                     playerInputFlag, btnLevel);
        end
        btn_n = 4'hF;
        tick(10);
    endtask

    task automatic test_reset_locked();
        pulse_arm();
        btn_n = 4'b0111;
        tick(12);
        checks++;
        if (playerInputFlag !== 1'b1 || firstPlayerFlag !== 2'd3) begin
            errors++;
            $display("FAIL pre_reset_lock: got pif=%b fpf=%0d, want 1 3",
                     playerInputFlag, firstPlayerFlag);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({playerInputFlag, firstPlayerFlag, armed, btnLevel} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %b, want 00000000",
                     {playerInputFlag, firstPlayerFlag, armed, btnLevel});
        end
        btn_n = 4'hF;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    initial begin
        rst   = 1'b0;
        btn_n = 4'hF;
        arm   = 1'b0;
        clear = 1'b0;
        test_reset();
        test_basic_win();
        test_glitch();
        test_tie_break();
        test_held_before_arm();
        test_arm_clear_same();
        test_reset_locked();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
